// File: rtl/alu_sequencer.sv
// Four-cycle issue controller for the combinational ALU.
// Owns the 16x16 register file and the 5-bit PSR (Z C F N L).
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inst_in,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int REGS = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [7:0]  alu_op_q, alu_op_d;
    logic        ill_q, ill_d;
    logic        wr_reg_q, wr_reg_d;
    logic        wr_psr_q, wr_psr_d;
    logic [15:0] c_q, c_d;
    logic [4:0]  flags_q, flags_d;
    logic [4:0]  psr_q, psr_d;
    logic [15:0] regs_q [REGS];
    logic [15:0] regs_d [REGS];

    logic [3:0]  op_hi, rd, ext, rs;
    logic [15:0] imm_sext, imm_zext;

    assign op_hi    = inst_q[15:12];
    assign rd       = inst_q[11:8];
    assign ext      = inst_q[7:4];
    assign rs       = inst_q[3:0];
    assign imm_sext = {{8{inst_q[7]}}, inst_q[7:0]};
    assign imm_zext = {8'h00, inst_q[7:0]};

    logic        dec_legal;
    logic        dec_wr_reg;
    logic        dec_wr_psr;
    logic [7:0]  dec_op;
    logic [15:0] dec_b;

    always_comb begin
        dec_legal  = 1'b1;
        dec_wr_reg = 1'b1;
        dec_wr_psr = 1'b1;
        dec_op     = 8'h00;
        dec_b      = 16'h0000;
        unique case (op_hi)
            4'h0: begin
                dec_op = {4'h0, ext};
                dec_b  = regs_q[rs];
                unique case (ext)
                    4'h0: begin
                        dec_wr_reg = 1'b0;
                        dec_wr_psr = 1'b0;
                    end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                    4'h6, 4'h7, 4'h8, 4'h9: dec_wr_reg = 1'b1;
                    4'hB: dec_wr_reg = 1'b0;
                    default: dec_legal = 1'b0;
                endcase
            end
            4'h5, 4'h7, 4'h9: begin
                dec_op = {4'h0, op_hi};
                dec_b  = imm_sext;
            end
            4'h6: begin
                dec_op = 8'h06;
                dec_b  = imm_zext;
            end
            4'hB: begin
                dec_op     = 8'h0B;
                dec_b      = imm_sext;
                dec_wr_reg = 1'b0;
            end
            4'h8: begin
                unique case (ext)
                    4'h0: begin
                        dec_op = 8'h80;
                        dec_b  = {12'h000, rs};
                    end
                    4'h4: begin
                        dec_op = 8'h84;
                        dec_b  = regs_q[rs];
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_wr_reg = 1'b0;
            dec_wr_psr = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        ill_d    = ill_q;
        wr_reg_d = wr_reg_q;
        wr_psr_d = wr_psr_q;
        c_d      = c_q;
        flags_d  = flags_q;
        psr_d    = psr_q;
        regs_d   = regs_q;
        unique case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ill_d    = !dec_legal;
                wr_reg_d = dec_wr_reg;
                wr_psr_d = dec_wr_psr;
                // Illegal words leave the ALU operands untouched
                if (dec_legal) begin
                    alu_a_d  = regs_q[rd];
                    alu_b_d  = dec_b;
                    alu_op_d = dec_op;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d     = alu_c;
                flags_d = alu_flags;
                state_d = S_WB;
            end
            S_WB: begin
                if (wr_reg_q) regs_d[rd] = c_q;
                if (wr_psr_q) psr_d = flags_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            inst_q   <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            ill_q    <= 1'b0;
            wr_reg_q <= 1'b0;
            wr_psr_q <= 1'b0;
            c_q      <= '0;
            flags_q  <= '0;
            psr_q    <= '0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            ill_q    <= ill_d;
            wr_reg_q <= wr_reg_d;
            wr_psr_q <= wr_psr_d;
            c_q      <= c_d;
            flags_q  <= flags_d;
            psr_q    <= psr_d;
            regs_q   <= regs_d;
        end
    end

    assign inst_ready = (state_q == S_IDLE);
    assign done       = (state_q == S_WB);
    assign illegal    = (state_q == S_WB) && ill_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign psr        = psr_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-issuing controller for the combinational `ALU`. Accepts 16-bit instruction words over a valid/ready handshake, decodes them into the ALU's 8-bit `Opcode` plus `A`/`B` operands, and captures `C`/`Flags`. It owns a 16x16 register file and the 5-bit processor status register (PSR). One instruction is processed at a time, four cycles each.

## Interface
- `REGS`, 16: register-file depth; fixed, register addresses are 4 bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `inst_in`  in  16  instruction word: [15:12] opHi, [11:8] Rdest, [7:4] opExt/immHi, [3:0] Rsrc/immLo.
- `inst_valid`  in  1  `inst_in` is valid.
- `inst_ready`  out  1  sequencer can accept an instruction.
- `alu_a`, `alu_b`  out  16  registered operands to ALU `A`, `B`.
- `alu_opcode`  out  8  registered ALU `Opcode`.
- `alu_c`  in  16  ALU `C`.
- `alu_flags`  in  5  ALU `Flags`, Z C F N L = [4:0].
- `psr`  out  5  processor status register, same bit order.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse, together with `done`, for an undecodable instruction.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  16  combinational read of R[`dbg_addr`].

## Operation
- **Decode**: imm8 = inst[7:4:0]. sext = sign-extend to 16 bits; zext = zero-extend to 16 bits. Opcode is written hi_lo.
  - opHi 0000, ext ∈ {1–9, B}: opcode = {0000, ext}, A = R[dst], B = R[src].
  - opHi 0000, ext 0: NOP.
  - opHi 0000, other ext values (including F): illegal.
  - 0101 ADDI: opcode 0000_0101, B = sext.
  - 0110 ADDUI: opcode 0000_0110, B = zext.
  - 0111 ADDCI: opcode 0000_0111, B = sext.
  - 1001 SUBI: opcode 0000_1001, B = sext.
  - 1011 CMPI: opcode 0000_1011, B = sext.
  - 1000, ext 0000 (LSHI): opcode 1000_0000, B = zext(inst[3:0]).
  - 1000, ext 0100 (LSH): opcode 1000_0100, B = R[src].
  - 1000, other ext values: illegal.
  - Every other opHi: illegal.
  - A = R[dst] for all non-illegal instructions.
- **Writeback**:
  - R[dst] ← captured C for all legal instructions except NOP, CMP (0000_1011) and CMPI.
  - PSR ← captured Flags for all legal instructions except NOP.
  - Illegal instructions and NOP change neither the register file nor the PSR.
- **FSM states**: IDLE, DECODE, EXEC, WB.
  - IDLE: `inst_ready`=1. On `inst_valid`, latch `inst_in` and go to DECODE.
  - DECODE: on the clock edge, register `alu_a`/`alu_b`/`alu_opcode` and the decode class; go to EXEC.
  - EXEC: ALU output settles. On the clock edge, capture `alu_c`/`alu_flags`; go to WB.
  - WB: `done`=1 (and `illegal`=1 if the instruction is illegal). Register/PSR write occurs on this state's closing edge; go to IDLE.
  - For illegal instructions in DECODE, do not update the `alu_*` outputs; the FSM still passes through EXEC and WB.
- `alu_*` outputs hold their last values while in IDLE.
- R0 is an ordinary register.
- `dbg_data` reflects a write starting the cycle after WB.

## Timing
- **Reset** (`reset`=0 at a clock edge):
  - State → IDLE.
  - All registers, `psr`, `alu_a`, `alu_b`, `alu_opcode` → 0.
  - `done`, `illegal` → 0; `inst_ready` → 1 in the following cycle.
- Reset takes priority over everything. Reset in DECODE, EXEC or WB aborts the instruction with no writeback and no `done`.
- **Latency**: instruction accepted at edge 0 → `done` high during cycle 3 → result visible on `dbg_data` in cycle 4.
- **Throughput**: one instruction per 4 cycles. Back-to-back accept is allowed in the IDLE cycle right after WB.
- `inst_ready` is 0 in DECODE, EXEC and WB. `inst_valid` during those states is ignored; the instruction is not queued and not accepted twice.
- A held `inst_valid` with an unchanged word in IDLE is accepted again as a new instruction. The producer must drop `inst_valid` after acceptance.
- Arithmetic and flag semantics are entirely the ALU's; the sequencer adds no width extension beyond the imm8/imm4 extension above.

## Test plan
- **ADDI, negative immediate**: after reset, ADDI r1,#0xFF (0x51FF) → `done` in cycle 3; r1=0xFFFF; psr=00000; `alu_opcode`=0x05, `alu_b`=0xFFFF.
- **Overflow via ADD**: ADDI r1,#0x40 (0x5140); LSHI r1,#8 (0x8108); ADD r1,r1 (0x0151) → r1 after LSHI=0x4000; r1 after ADD=0x8000; psr=00100 (F set).
- **CMPI, no writeback**: ADDI r2,#5 (0x5205); CMPI r2,#10 (0xB20A) → r2 stays 0x0005; psr=00011.
- **Illegal and NOP**: inst 0x2123 → `illegal` and `done` together in cycle 3; registers and psr unchanged. Then 0x0000 (NOP) → `done` only; psr unchanged.
- **Handshake**: hold `inst_valid`=1 with 0x5101 for 8 cycles → exactly two accepts (cycles 0 and 4); r1=0x0002; `inst_ready` low in cycles 1–3 and 5–7.
- **Reset mid-operation**: issue ADDI r3,#7; assert `reset`=0 during EXEC → no `done`; r3=0; psr=0; `inst_ready`=1 the cycle after reset is released.
